// File: rtl/systolic_feeder.sv
// Buffers an A and a B tile, then streams them diagonally skewed into an N x N systolic array.
// Row lane i carries A[i][t-i] and column lane j carries B[t-j][j] in streaming cycle t.
module systolic_feeder #(
  parameter int N     = 4,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [WIDTH-1:0]     load_data,
  output logic                 load_ready,
  input  logic                 start,
  output logic [N*WIDTH-1:0]   out_row,
  output logic [N*WIDTH-1:0]   out_col,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int TILE = N * N;
  localparam int LW   = $clog2(2 * TILE + 1);
  localparam int AW   = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int SW   = $clog2(3 * N);
  localparam logic [LW-1:0] LAST_LOAD = LW'(2 * TILE - 1);
  localparam logic [LW-1:0] TILE_L    = LW'(TILE);
  localparam logic [SW-1:0] LAST_T    = SW'(3 * N - 3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       load_cnt_q, load_cnt_d;
  logic [SW-1:0]       stream_cnt_q, stream_cnt_d;
  logic [N*WIDTH-1:0]  out_row_q, out_row_d;
  logic [N*WIDTH-1:0]  out_col_q, out_col_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    a_mem_q [TILE];
  logic [WIDTH-1:0]    b_mem_q [TILE];
  logic                accept_s, wr_sel_b_s, a_we_s, b_we_s;
  logic [AW-1:0]       wr_addr_s;

  assign load_ready = (state_q == S_IDLE) && !rst;
  assign accept_s   = load_valid && load_ready;
  assign wr_sel_b_s = (load_cnt_q >= TILE_L);
  assign wr_addr_s  = wr_sel_b_s ? AW'(load_cnt_q - TILE_L) : AW'(load_cnt_q);

  // Next-state, counter and tile-write decode.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    stream_cnt_d = stream_cnt_q;
    a_we_s       = 1'b0;
    b_we_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          load_cnt_d = load_cnt_q + LW'(1);
          a_we_s     = !wr_sel_b_s;
          b_we_s     = wr_sel_b_s;
          state_d    = (load_cnt_q == LAST_LOAD) ? S_LOADED : S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOADED: begin
        if (start) begin
          state_d      = S_STREAM;
          stream_cnt_d = '0;
        end else begin
          state_d = S_LOADED;
        end
      end
      S_STREAM: begin
        if (stream_cnt_q == LAST_T) begin
          state_d = S_DONE;
        end else begin
          stream_cnt_d = stream_cnt_q + SW'(1);
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        load_cnt_d   = '0;
        stream_cnt_d = '0;
      end
      default: begin
        state_d      = S_IDLE;
        load_cnt_d   = '0;
        stream_cnt_d = '0;
      end
    endcase
  end

  // Lane values are computed for the cycle being entered so the outputs can be registered.
  always_comb begin : lane_select
    int t;
    int k;
    t           = int'(stream_cnt_d);
    k           = 0;
    out_row_d   = '0;
    out_col_d   = '0;
    out_valid_d = (state_d == S_STREAM);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    if (state_d == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        k = t - i;
        if (k >= 0 && k < N) begin
          out_row_d[i*WIDTH +: WIDTH] = a_mem_q[AW'(i * N + k)];
          out_col_d[i*WIDTH +: WIDTH] = b_mem_q[AW'(k * N + i)];
        end else begin
          out_row_d[i*WIDTH +: WIDTH] = '0;
          out_col_d[i*WIDTH +: WIDTH] = '0;
        end
      end
    end else begin
      out_row_d = '0;
      out_col_d = '0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      stream_cnt_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      stream_cnt_q <= stream_cnt_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Tile storage carries no reset; only accepted loads write it.
  always_ff @(posedge clk) begin
    if (a_we_s) begin
      a_mem_q[wr_addr_s] <= load_data;
    end else if (b_we_s) begin
      b_mem_q[wr_addr_s] <= load_data;
    end
  end

  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder; expected lanes come from the tile model and the skew rule.
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int W = 32;
  localparam int T = N * N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [W-1:0]     load_data = '0;
  logic             load_ready;
  logic             start = 1'b0;
  logic [N*W-1:0]   out_row, out_col;
  logic             out_valid, busy, done;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] ma [T];
  logic [W-1:0] mb [T];

  systolic_feeder #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word_at(int idx);
    return (idx < T) ? ma[idx] : mb[idx - T];
  endfunction

  function automatic logic [W-1:0] exp_row(int t, int i);
    int k = t - i;
    return (k >= 0 && k < N) ? ma[i*N + k] : '0;
  endfunction

  function automatic logic [W-1:0] exp_col(int t, int j);
    int k = t - j;
    return (k >= 0 && k < N) ? mb[k*N + j] : '0;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < T; i++) begin
      ma[i] = $urandom();
      mb[i] = $urandom();
    end
  endtask

  // Loads words first..last-1 of the A-then-B sequence; extra_cycles keeps load_valid high afterwards.
  task automatic load_words(int first, int last, bit gaps, int extra_cycles, int start_at);
    int idx = first;
    int guard = 0;
    bit v;
    bit start_sent = 1'b0;
    while (idx < last && guard < 2000) begin
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      checks++;
      if (load_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL load_idle word=%0d: load_ready=%b busy=%b expected 1 0", idx, load_ready, busy);
      end
      load_valid = v;
      load_data  = v ? word_at(idx) : $urandom();
      start      = (idx == start_at && !start_sent);
      if (start) start_sent = 1'b1;
      tick();
      if (v) idx++;
      guard++;
    end
    start = 1'b0;
    checks++;
    if (idx < last) begin
      failures++;
      $display("FAIL load_timeout: loaded %0d expected %0d", idx, last);
    end
    for (int e = 0; e < extra_cycles; e++) begin
      load_valid = 1'b1;
      load_data  = $urandom();
      checks++;
      if (load_ready !== 1'b0) begin
        failures++;
        $display("FAIL load_ready_after_full extra=%0d: got %b expected 0", e, load_ready);
      end
      tick();
    end
    load_valid = 1'b0;
  endtask

  // Starts and checks a stream; abort_at >= 0 asserts rst in that cycle, start_at_t re-pulses start.
  task automatic run_stream(int abort_at, int start_at_t);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL loaded_state: busy=%b out_valid=%b load_ready=%b expected 1 0 0", busy, out_valid, load_ready);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 3*N - 2; t++) begin
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL stream_valid t=%0d: out_valid=%b done=%b expected 1 0", t, out_valid, done);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (out_row[i*W +: W] !== exp_row(t, i)) begin
          failures++;
          $display("FAIL row_lane%0d t=%0d: got %h expected %h", i, t, out_row[i*W +: W], exp_row(t, i));
        end
        checks++;
        if (out_col[i*W +: W] !== exp_col(t, i)) begin
          failures++;
          $display("FAIL col_lane%0d t=%0d: got %h expected %h", i, t, out_col[i*W +: W], exp_col(t, i));
        end
      end
      if (t == abort_at) begin
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_row !== '0 || out_col !== '0 || done !== 1'b0 ||
            busy !== 1'b0 || load_ready !== 1'b0) begin
          failures++;
          $display("FAIL abort_outputs: valid=%b row=%h col=%h done=%b busy=%b ready=%b expected all 0",
                   out_valid, out_row, out_col, done, busy, load_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
          failures++;
          $display("FAIL abort_ready: got %b expected 1", load_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL abort_no_done: done=%b out_valid=%b expected 0 0", done, out_valid);
        end
        return;
      end
      start = (t == start_at_t);
      tick();
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || out_row !== '0 || out_col !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_cycle: done=%b valid=%b row=%h col=%h busy=%b expected 1 0 0 0 1",
               done, out_valid, out_row, out_col, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL back_to_idle: done=%b busy=%b ready=%b valid=%b expected 0 0 1 0",
               done, busy, load_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_row !== '0 || out_col !== '0 || done !== 1'b0 ||
        busy !== 1'b0 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b row=%h col=%h done=%b busy=%b ready=%b expected all 0",
               out_valid, out_row, out_col, done, busy, load_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", load_ready);
    end
  endtask

  task automatic test_basic_stream();
    for (int i = 0; i < T; i++) begin
      ma[i] = W'(i + 1);
      mb[i] = W'(i + 1 + T);
    end
    load_words(0, 2*T, 1'b0, 0, -1);
    run_stream(-1, -1);
  endtask

  task automatic test_backpressure();
    load_words(0, 2*T, 1'b1, 3, -1);
    run_stream(-1, -1);
  endtask

  task automatic test_ignored_start();
    fill_random();
    load_words(0, 2*T, 1'b1, 0, 10);
    run_stream(-1, 4);
  endtask

  task automatic test_reset_mid_stream();
    fill_random();
    load_words(0, 2*T, 1'b0, 0, -1);
    run_stream(5, -1);
    // A fresh 16-word load lands in the A buffer; the counter restarted, so the block stays in IDLE.
    for (int i = 0; i < T; i++) ma[i] = $urandom();
    load_words(0, T, 1'b1, 0, -1);
    tick();
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL partial_reload_idle: busy=%b ready=%b valid=%b expected 0 1 0", busy, load_ready, out_valid);
    end
    for (int i = 0; i < T; i++) mb[i] = $urandom();
    load_words(T, 2*T, 1'b1, 0, -1);
    run_stream(-1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < T; i++) begin
      ma[i] = 32'hFFFF_FFFF;
      mb[i] = 32'hFFFF_FFFF;
    end
    load_words(0, 2*T, 1'b0, 0, -1);
    run_stream(-1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      load_words(0, 2*T, 1'b1, $urandom_range(0, 2), -1);
      run_stream(-1, -1);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_stream();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
